// File: rtl/i2s_tdm_tx_unit.sv
// i2s_tdm_tx_unit: parametrised I2S / left-justified / TDM serial audio transmitter.
// Double-buffered: the datapath fills an input buffer on tick_in; the buffer moves into
// the shift register at every frame boundary and req_out asks for the next sample set.
module i2s_tdm_tx_unit #(
  parameter int DATA_W   = 24,
  parameter int CHANNELS = 2,
  parameter int CFG_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         play_in,
  input  logic [CHANNELS*DATA_W-1:0]   audio_in,
  input  logic                         tick_in,
  output logic                         req_out,
  input  logic                         cfg_in,
  input  logic [CFG_W-1:0]             cfg_reg_in,
  output logic                         sck_out,
  output logic                         ws_out,
  output logic                         sdo_out,
  output logic                         underrun_out
);

  localparam int F     = CHANNELS * DATA_W;
  localparam int BIT_W = $clog2(F);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                             state;
  logic [1:0]                         hsel;
  logic                               lj_mode;
  logic [1:0]                         div_cnt;
  logic [BIT_W-1:0]                   bit_idx;
  logic                               start;
  logic [CHANNELS-1:0][DATA_W-1:0]    in_buf;
  logic                               buf_full;
  logic [F-1:0]                       sr;
  logic [F-1:0]                       buf_frame;

  // only the low three config bits carry meaning
  logic unused_cfg;
  assign unused_cfg = ^cfg_reg_in[CFG_W-1:3];

  // reorder the buffer into transmission order: channel 0 MSB lands in the top bit
  for (genvar c = 0; c < CHANNELS; c++) begin : g_frame
    assign buf_frame[F-1-c*DATA_W -: DATA_W] = in_buf[c];
  end

  // half-period minus one from the selector; code 11 falls back to the slowest rate
  logic [1:0] hm1;
  always_comb begin
    case (hsel)
      2'b01:   hm1 = 2'd1;
      2'b10:   hm1 = 2'd0;
      default: hm1 = 2'd3;
    endcase
  end

  // sck falls this edge; a frame boundary is the fall that ends the last bit of the frame
  logic             fall, boundary, nxt_lj;
  logic [BIT_W-1:0] nxt_idx;
  always_comb begin
    fall     = sck_out && (div_cnt == hm1);
    boundary = fall && (bit_idx == BIT_W'(F-1));
    nxt_idx  = boundary ? '0 : bit_idx + BIT_W'(1);
    if (boundary) nxt_lj = buf_full ? buf_frame[F-1] : 1'b0;
    else          nxt_lj = sr[F-2];
  end

  // word select for a given bit position of the frame
  function automatic logic ws_of(input logic [BIT_W-1:0] idx);
    if (CHANNELS == 2) return idx >= BIT_W'(DATA_W);
    else               return idx == '0;
  endfunction

  // control FSM, clock divider, serialiser and buffering
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hsel         <= 2'b00;
      lj_mode      <= 1'b0;
      div_cnt      <= '0;
      bit_idx      <= '0;
      start        <= 1'b0;
      in_buf       <= '0;
      buf_full     <= 1'b0;
      sr           <= '0;
      req_out      <= 1'b0;
      sck_out      <= 1'b0;
      ws_out       <= 1'b0;
      sdo_out      <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_in) begin
            hsel         <= cfg_reg_in[1:0];
            lj_mode      <= cfg_reg_in[2];
            underrun_out <= 1'b0;
          end
          if (play_in) begin
            state   <= RUN;
            div_cnt <= '0;
            bit_idx <= '0;
            start   <= 1'b1;
            sr      <= '0;
          end
        end
        RUN: begin
          if (!play_in) begin
            state    <= IDLE;
            sck_out  <= 1'b0;
            ws_out   <= 1'b0;
            sdo_out  <= 1'b0;
            req_out  <= 1'b0;
            in_buf   <= '0;
            buf_full <= 1'b0;
            sr       <= '0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            start    <= 1'b0;
          end else begin
            req_out <= 1'b0;
            // first cycle of a run: present bit 0 and prefetch the first real frame
            if (start) begin
              start   <= 1'b0;
              req_out <= 1'b1;
              ws_out  <= ws_of('0);
              sdo_out <= 1'b0;
            end
            if (div_cnt == hm1) begin
              div_cnt <= '0;
              sck_out <= ~sck_out;
            end else begin
              div_cnt <= div_cnt + 2'd1;
            end
            if (fall) begin
              bit_idx <= nxt_idx;
              ws_out  <= ws_of(nxt_idx);
              // I2S repeats the bit just finished, so data trails ws by one sck period
              sdo_out <= lj_mode ? nxt_lj : sr[F-1];
              if (boundary) begin
                sr       <= buf_full ? buf_frame : '0;
                buf_full <= 1'b0;
                req_out  <= 1'b1;
                if (!buf_full) underrun_out <= 1'b1;
              end else begin
                sr <= {sr[F-2:0], 1'b0};
              end
            end
            // placed last so a tick on the boundary cycle survives for the next frame
            if (tick_in) begin
              in_buf   <= audio_in;
              buf_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx_unit.sv
// Bench for i2s_tdm_tx_unit: a stereo and a 4-channel TDM instance, random sample data and
// tick timing, compared cycle by cycle against a position-arithmetic model of the stream.
module tb_i2s_tdm_tx_unit;
  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] cfg_reg;
  logic        play_a, tick_a, cfg_a, req_a, sck_a, ws_a, sdo_a, ur_a;
  logic        play_b, tick_b, cfg_b, req_b, sck_b, ws_b, sdo_b, ur_b;
  logic [47:0] audio_a;
  logic [95:0] audio_b;

  i2s_tdm_tx_unit #(.DATA_W(DW), .CHANNELS(2), .CFG_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .play_in(play_a), .audio_in(audio_a), .tick_in(tick_a),
    .req_out(req_a), .cfg_in(cfg_a), .cfg_reg_in(cfg_reg), .sck_out(sck_a), .ws_out(ws_a),
    .sdo_out(sdo_a), .underrun_out(ur_a));

  i2s_tdm_tx_unit #(.DATA_W(DW), .CHANNELS(4), .CFG_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .play_in(play_b), .audio_in(audio_b), .tick_in(tick_b),
    .req_out(req_b), .cfg_in(cfg_b), .cfg_reg_in(cfg_reg), .sck_out(sck_b), .ws_out(ws_b),
    .sdo_out(sdo_b), .underrun_out(ur_b));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got %b expected %b", tag, $time, act, exp);
    end
  endtask

  // per-instance model of the configuration and sticky underrun
  int          m_hsel [2];
  bit          m_lj   [2];
  bit          m_ur   [2];
  // frame contents (channel c at [c*DW +: DW]) and tick plan per frame
  logic [95:0] fd [0:15];
  logic [95:0] d1 [0:15];
  logic [95:0] d2 [0:15];
  int          t1 [0:15];
  int          t2 [0:15];

  function automatic int h_of(input int s);
    case (s)
      1:       return 2;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  // bit k of frame f, MSB of each channel first
  function automatic logic fbit(input int f, input int k);
    int c, b;
    logic [95:0] w;
    if (f < 0 || f > 15) return 1'b0;
    c = k / DW;
    b = DW - 1 - (k % DW);
    w = fd[f];
    return w[c*DW + b];
  endfunction

  task automatic set_play(input int sel, input logic v);
    if (sel == 1) play_b = v; else play_a = v;
  endtask

  task automatic set_cfg(input int sel, input logic v);
    if (sel == 1) cfg_b = v; else cfg_a = v;
  endtask

  task automatic drive_tick(input int sel, input logic v, input logic [95:0] d);
    if (sel == 1) begin tick_b = v; audio_b = d; end
    else          begin tick_a = v; audio_a = d[47:0]; end
  endtask

  task automatic chk_out(input int sel, input string tag, input logic s, input logic w,
                         input logic d, input logic r, input logic u);
    chk({tag, ".sck"}, sel == 1 ? sck_b : sck_a, s);
    chk({tag, ".ws"},  sel == 1 ? ws_b  : ws_a,  w);
    chk({tag, ".sdo"}, sel == 1 ? sdo_b : sdo_a, d);
    chk({tag, ".req"}, sel == 1 ? req_b : req_a, r);
    chk({tag, ".ur"},  sel == 1 ? ur_b  : ur_a,  u);
  endtask

  // config write while idle; also clears the sticky underrun
  task automatic cfg_write(input int sel, input logic [31:0] v);
    @(negedge clk);
    cfg_reg = v;
    set_cfg(sel, 1'b1);
    @(negedge clk);
    set_cfg(sel, 1'b0);
    m_hsel[sel] = int'(v[1:0]);
    m_lj[sel]   = v[2];
    m_ur[sel]   = 1'b0;
    chk("cfg_clr.ur", sel == 1 ? ur_b : ur_a, 1'b0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_hsel[i] = 0; m_lj[i] = 1'b0; m_ur[i] = 1'b0;
    end
  endtask

  // one play run: n counts posedges after the start edge; the run ends by dropping
  // play_in (or by a mid-run reset) after n_end cycles
  task automatic session(input int sel, input int nframes, input int n_end, input int skip,
                         input int cfgplay_n, input bit use_first,
                         input logic [95:0] first_data, input bit rst_mid);
    int ch, F, H, P, FC, p, q;
    bit lj, e_sck, e_ws, e_sdo, e_req, e_ur, tk;
    logic [95:0] td;
    ch = (sel == 1) ? 4 : 2;
    F  = ch * DW;
    H  = h_of(m_hsel[sel]);
    P  = 2 * H;
    FC = P * F;
    lj = m_lj[sel];
    e_ur = m_ur[sel];
    fd[0] = '0;
    for (int f = 1; f < 16; f++) begin
      t1[f] = -1; t2[f] = -1; fd[f] = '0;
      if (f != skip && f <= nframes + 1) begin
        if (f >= 2 && $urandom_range(0, 2) == 0) t1[f] = (f - 1) * FC;
        else t1[f] = (f - 1) * FC + 1 + int'($urandom_range(0, FC / 2));
        d1[f] = (f == 1 && use_first) ? first_data : {$urandom, $urandom, $urandom};
        fd[f] = d1[f];
        if ($urandom_range(0, 3) == 0) begin
          t2[f] = t1[f] + 3 + int'($urandom_range(0, FC / 4));
          d2[f] = {$urandom, $urandom, $urandom};
          fd[f] = d2[f];
        end
      end
    end
    @(negedge clk);
    set_play(sel, 1'b1);
    @(posedge clk);
    for (int n = 0; n < n_end; n++) begin
      @(negedge clk);
      e_ur = m_ur[sel] || (skip > 0 && n >= skip * FC);
      if (n == 0) begin
        e_sck = 0; e_ws = 0; e_sdo = 0; e_req = 0;
      end else begin
        p     = n / P;
        q     = p % F;
        e_sck = ((n / H) % 2) == 1;
        e_ws  = (ch == 2) ? (q >= DW) : (q == 0);
        if (lj)          e_sdo = fbit(p / F, q);
        else if (p == 0) e_sdo = 1'b0;
        else             e_sdo = fbit((p - 1) / F, (p - 1) % F);
        e_req = (n == 1) || (n % FC == 0);
      end
      chk_out(sel, "run", e_sck, e_ws, e_sdo, e_req, e_ur);
      tk = 1'b0;
      td = {$urandom, $urandom, $urandom};
      for (int f = 1; f < 16; f++) begin
        if (t1[f] == n + 1) begin tk = 1'b1; td = d1[f]; end
        if (t2[f] == n + 1) begin tk = 1'b1; td = d2[f]; end
      end
      drive_tick(sel, tk, td);
      if (n + 1 == cfgplay_n) begin
        cfg_reg = 32'h0000_0006;
        set_cfg(sel, 1'b1);
      end else begin
        set_cfg(sel, 1'b0);
      end
      if (n == n_end - 1 && !rst_mid) set_play(sel, 1'b0);
    end
    if (!rst_mid) begin
      @(negedge clk);
      drive_tick(sel, 1'b0, '0);
      chk_out(sel, "stop", 1'b0, 1'b0, 1'b0, 1'b0, e_ur);
      m_ur[sel] = e_ur;
    end else begin
      #2 rst_n = 1'b0;
      #1;
      chk_out(0, "arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_out(1, "arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_play(sel, 1'b0);
      drive_tick(sel, 1'b0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk_out(sel, "post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_reg = '0;
    play_a = 0; tick_a = 0; cfg_a = 0; audio_a = '0;
    play_b = 0; tick_b = 0; cfg_b = 0; audio_b = '0;
    reset_model();
    #12;
    chk_out(0, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out(1, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // stereo, default H=4, I2S, known first frame, frame 3 withheld
    session(0, 4, 4*384 + 100, 3, -1, 1'b1, {48'h0, 24'h5A5A5A, 24'hA5A5A5}, 1'b0);
    repeat (5) @(negedge clk);
    chk("idle_sticky.ur", ur_a, 1'b1);
    // H=2, left-justified; a config strobe during play must be ignored
    cfg_write(0, 32'h0000_0005);
    session(0, 3, 3*192 + 37, 0, 50, 1'b1, {48'h0, 24'h3C3C3C, 24'h800001}, 1'b0);
    // H=1, I2S, frame 2 withheld
    cfg_write(0, 32'h0000_0002);
    session(0, 4, 4*96 + 11, 2, -1, 1'b0, '0, 1'b0);
    // TDM 4 channels, H=2, I2S, play dropped mid-frame
    cfg_write(1, 32'h0000_0001);
    session(1, 3, 3*384 + 150, 0, -1, 1'b0, '0, 1'b0);
    // TDM, selector 11 behaves as H=4, left-justified, reset in the middle of the run
    cfg_write(1, 32'h0000_0007);
    session(1, 2, 500, 0, -1, 1'b0, '0, 1'b1);
    // configuration back to defaults after reset: H=4, I2S
    session(1, 1, 800, 0, -1, 1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
